// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and S-box lookup.
//   BLOCK_BITS / BLOCK_BYTES : AES state width in bits / bytes
//   state_t                  : engine FSM states (IDLE, BUSY, DONE)
//   SBOX_FWD / SBOX_INV      : FIPS-197 forward / inverse substitution tables
//   sbox(inv, b)             : table lookup, inv=1 selects the inverse table
package aes_pkg;

  localparam int unsigned BLOCK_BITS  = 128;
  localparam int unsigned BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic inv, input logic [7:0] b);
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational forward/inverse AES substitution.
//   i_inv  : 0 = forward S-box, 1 = inverse S-box
//   i_byte : byte to substitute
//   o_byte : substituted byte
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic       i_inv,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = sbox(i_inv, i_byte);
  end

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes / InvSubBytes engine: substitutes LANES bytes of a
// 128-bit state per clock, ascending from byte 0, BEATS = 16/LANES cycles.
//   clk, rst_n           : rising-edge clock, async active-low reset
//   in_valid / in_ready  : input handshake (in_ready from state and out_ready only)
//   in_inv, in_state     : mode and state, sampled only on accept
//   out_valid / out_ready: output handshake, result held until taken
//   out_state            : substituted state, same byte order as in_state
//   busy                 : high while substituting
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_inv,
  input  logic [BLOCK_BITS-1:0] in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_BITS-1:0] out_state,
  output logic                  busy
);

  localparam int unsigned BEATS = BLOCK_BYTES / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_mode;
  logic [BLOCK_BITS-1:0] r_work;

  logic                  w_accept;
  logic                  w_last;
  int unsigned           w_base;
  logic [7:0]            w_lane_in  [LANES];
  logic [7:0]            w_lane_out [LANES];
  logic [BLOCK_BITS-1:0] w_work_next;

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CNT_W'(BEATS - 1));
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_BUSY);
  assign out_state = r_work;

  // First byte index of the group handled this beat.
  always_comb begin
    w_base = 32'(r_cnt) * LANES;
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane_in[l] = r_work[8*(w_base + l) +: 8];
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    aes_sbox_lane u_lane (
      .i_inv  (r_mode),
      .i_byte (w_lane_in[g]),
      .o_byte (w_lane_out[g])
    );
  end

  always_comb begin
    w_work_next = r_work;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_work_next[8*(w_base + l) +: 8] = w_lane_out[l];
    end
  end

  // Accept has priority: it can only occur in IDLE or in DONE with out_ready,
  // and in DONE it doubles as the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_work  <= '0;
    end else if (w_accept) begin
      r_state <= ST_BUSY;
      r_cnt   <= '0;
      r_mode  <= in_inv;
      r_work  <= in_state;
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_BUSY: begin
          r_work <= w_work_next;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
module tb_aes_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   iv, orr, ir, ov, bz;
  logic         inv_in;
  logic [127:0] st_in;
  logic [127:0] so0, so1, so2;

  int total = 0;
  int bad   = 0;

  // Instance index -> LANES: 0 -> 1, 1 -> 4, 2 -> 16
  int unsigned beats_of [3] = '{16, 4, 1};

  aes_sub_bytes_iter #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_inv(inv_in),
    .in_state(st_in), .out_valid(ov[0]), .out_ready(orr[0]), .out_state(so0), .busy(bz[0]));
  aes_sub_bytes_iter #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_inv(inv_in),
    .in_state(st_in), .out_valid(ov[1]), .out_ready(orr[1]), .out_state(so1), .busy(bz[1]));
  aes_sub_bytes_iter #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_inv(inv_in),
    .in_state(st_in), .out_valid(ov[2]), .out_ready(orr[2]), .out_state(so2), .busy(bz[2]));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference S-boxes derived from GF(2^8) inversion plus the affine map.
  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] affine_of_inverse(input logic [7:0] x);
    logic [7:0] v;
    v = (x == 8'h00) ? 8'h00 : 8'h01;
    if (x != 8'h00) for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_block(input logic inv, input logic [127:0] st);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = st[8*k +: 8];
      r[8*k +: 8] = inv ? ref_inv[b] : ref_fwd[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] get_out(input int d);
    case (d)
      0:       return so0;
      1:       return so1;
      default: return so2;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge with orr[d]=1. Accepts one block, scrambles
  // the inputs afterwards, and returns the result and accept-to-valid latency.
  task automatic run_block(input int d, input logic inv, input logic [127:0] st,
                           output logic [127:0] res, output int lat);
    int n;
    n = 0;
    while (!ir[d] && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", {127'd0, ir[d]}, 128'd1);
    inv_in = inv; st_in = st; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0; inv_in = $urandom_range(0, 1); st_in = rnd128();
    n = 0;
    while (!ov[d] && n < 40) begin @(posedge clk); #1; n++; end
    res = get_out(d);
    lat = n;
  endtask

  typedef struct {
    logic         inv;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] res, st, exp_a, exp_b, st_a;
    int           lat, n;

    rst_n = 1'b1; iv = '0; orr = 3'b111; inv_in = 1'b0; st_in = '0;
    for (int x = 0; x < 256; x++) ref_fwd[x] = affine_of_inverse(8'(x));
    for (int x = 0; x < 256; x++) ref_inv[ref_fwd[x]] = 8'(x);

    vecs[0] = '{1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63};
    vecs[1] = '{1'b1, 128'h76abd7fe2b670130c56f6bf27b777c63, 128'h0f0e0d0c0b0a09080706050403020100};
    vecs[2] = '{1'b1, 128'h0, {16{8'h52}}};
    vecs[3] = '{1'b0, {16{8'h53}}, {16{8'hed}}};
    vecs[4] = '{1'b1, {16{8'h63}}, 128'h0};
    vecs[5] = '{1'b0, 128'h0, {16{8'h63}}};

    #2 rst_n = 1'b0;
    #10;
    for (int d = 0; d < 3; d++) begin
      chk("reset_out_valid", {127'd0, ov[d]}, 128'd0);
      chk("reset_busy", {127'd0, bz[d]}, 128'd0);
      chk("reset_in_ready", {127'd0, ir[d]}, 128'd1);
      chk("reset_out_state", get_out(d), 128'd0);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors on every lane width
    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 6; v++) begin
        run_block(d, vecs[v].inv, vecs[v].st, res, lat);
        chk("kat_result", res, vecs[v].exp);
        chk("kat_latency", 128'(lat), 128'(beats_of[d]));
      end
    end

    // Every byte value in every position, both modes
    for (int d = 0; d < 3; d++) begin
      for (int m = 0; m < 2; m++) begin
        for (int j = 0; j < 256; j++) begin
          for (int k = 0; k < 16; k++) st[8*k +: 8] = 8'(j + k);
          run_block(d, m[0], st, res, lat);
          chk("sweep_result", res, ref_block(m[0], st));
          chk("sweep_latency", 128'(lat), 128'(beats_of[d]));
        end
      end
    end

    // Random blocks
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 40; r++) begin
        logic m;
        m = $urandom_range(0, 1);
        st = rnd128();
        run_block(d, m, st, res, lat);
        chk("rand_result", res, ref_block(m, st));
      end
    end

    // Backpressure then same-edge handoff (LANES=4)
    @(posedge clk); #1;
    orr[1] = 1'b0;
    st_a = rnd128();
    exp_a = ref_block(1'b0, st_a);
    inv_in = 1'b0; st_in = st_a; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    chk("bp_busy_after_accept", {127'd0, bz[1]}, 128'd1);
    n = 0;
    while (!ov[1] && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp_latency", 128'(n), 128'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid_held", {127'd0, ov[1]}, 128'd1);
      chk("bp_out_state_stable", so1, exp_a);
      chk("bp_in_ready_low", {127'd0, ir[1]}, 128'd0);
    end
    st = rnd128();
    exp_b = ref_block(1'b1, st);
    inv_in = 1'b1; st_in = st; iv[1] = 1'b1; orr[1] = 1'b1;
    #1 chk("handoff_in_ready", {127'd0, ir[1]}, 128'd1);
    @(posedge clk); #1;
    iv[1] = 1'b0;
    chk("handoff_out_valid_drop", {127'd0, ov[1]}, 128'd0);
    chk("handoff_busy", {127'd0, bz[1]}, 128'd1);
    n = 0;
    while (!ov[1] && n < 40) begin @(posedge clk); #1; n++; end
    chk("handoff_latency", 128'(n), 128'd4);
    chk("handoff_result", so1, exp_b);

    // Inputs changing during BUSY must not affect the result
    @(posedge clk); #1;
    st = rnd128();
    inv_in = 1'b0; st_in = st; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    n = 0;
    while (!ov[1] && n < 40) begin
      inv_in = ~inv_in; st_in = rnd128();
      @(posedge clk); #1; n++;
    end
    chk("toggle_result", so1, ref_block(1'b0, st));

    // Reset during the second BUSY cycle discards the block
    @(posedge clk); #1;
    inv_in = 1'b0; st_in = rnd128(); iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, ov[1]}, 128'd0);
    chk("midrst_busy", {127'd0, bz[1]}, 128'd0);
    chk("midrst_in_ready", {127'd0, ir[1]}, 128'd1);
    chk("midrst_out_state", so1, 128'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("postrst_no_output", {127'd0, ov[1]}, 128'd0);
      chk("postrst_in_ready", {127'd0, ir[1]}, 128'd1);
    end
    st = rnd128();
    run_block(1, 1'b1, st, res, lat);
    chk("postrst_result", res, ref_block(1'b1, st));
    chk("postrst_latency", 128'(lat), 128'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
